// File: rtl/icela_frame_rx_pkg.sv
// Shared constants, state codes and payload layout for the icela frame receiver.
package icela_frame_rx_pkg;

  localparam logic [7:0]  SYNC_BYTE    = 8'h0A;
  localparam int unsigned FRAME_LEN    = 5;
  localparam int unsigned OS_WIDTH_DEF = 10;
  localparam int unsigned OS_INCR_DEF  = 157;

  // Bit-level receiver states
  localparam logic [2:0] BIT_IDLE  = 3'd0;
  localparam logic [2:0] BIT_START = 3'd1;
  localparam logic [2:0] BIT_DATA  = 3'd2;
  localparam logic [2:0] BIT_STOP  = 3'd3;
  localparam logic [2:0] BIT_BRK   = 3'd4;

  // Frame-level decoder states
  localparam logic [2:0] FRM_HUNT = 3'd0;
  localparam logic [2:0] FRM_P0   = 3'd1;
  localparam logic [2:0] FRM_P1   = 3'd2;
  localparam logic [2:0] FRM_P2   = 3'd3;
  localparam logic [2:0] FRM_P3   = 3'd4;

  // Decoded capture word
  typedef struct packed {
    logic [23:0] timebase;
    logic        oflow;
    logic [6:0]  pin;
  } icela_word_t;

  // Saturating 8-bit increment
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/icela_frame_rx_uart_rx_os.sv
// 8N1 UART receiver: 2-FF synchroniser, fractional 16x oversample tick, bit FSM.
module uart_rx_os
  import icela_frame_rx_pkg::*;
#(
  parameter int unsigned OS_WIDTH = OS_WIDTH_DEF,
  parameter int unsigned OS_INCR  = OS_INCR_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_stb,
  output logic       frame_err
);

  localparam int unsigned SUM_W = OS_WIDTH + 1;

  logic                rx_meta_q, rxs_q;
  logic [OS_WIDTH-1:0] acc_q;
  logic [SUM_W-1:0]    acc_sum_c;
  logic                os_tick_c;

  logic [2:0] state_q, state_d;
  logic [3:0] tcnt_q, tcnt_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic       byte_stb_q, byte_stb_d;
  logic       frame_err_q, frame_err_d;

  assign acc_sum_c = {1'b0, acc_q} + SUM_W'(OS_INCR);
  assign os_tick_c = acc_sum_c[OS_WIDTH];

  // Synchroniser (reset to idle-high so reset never looks like a start bit) and tick accumulator
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      acc_q     <= '0;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
      acc_q     <= acc_sum_c[OS_WIDTH-1:0];
    end
  end

  // Bit FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= BIT_IDLE;
      tcnt_q      <= '0;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      byte_stb_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      byte_stb_q  <= byte_stb_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Bit FSM next state: mid-bit sampling, 16 ticks per bit after the start-bit midpoint
  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    byte_stb_d  = 1'b0;
    frame_err_d = 1'b0;
    if (os_tick_c) begin
      case (state_q)
        BIT_IDLE: begin
          if (!rxs_q) begin
            state_d = BIT_START;
            tcnt_d  = '0;
          end
        end
        BIT_START: begin
          if (tcnt_q == 4'd7) begin
            if (rxs_q) begin
              state_d = BIT_IDLE;
            end else begin
              state_d  = BIT_DATA;
              tcnt_d   = '0;
              bitcnt_d = '0;
            end
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
        BIT_DATA: begin
          if (tcnt_q == 4'd15) begin
            tcnt_d  = '0;
            shreg_d = {rxs_q, shreg_q[7:1]};
            if (bitcnt_q == 3'd7) begin
              state_d = BIT_STOP;
            end else begin
              bitcnt_d = bitcnt_q + 3'd1;
            end
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
        BIT_STOP: begin
          if (tcnt_q == 4'd15) begin
            tcnt_d = '0;
            if (rxs_q) begin
              byte_stb_d = 1'b1;
              state_d    = BIT_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = BIT_BRK;
            end
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
        BIT_BRK: begin
          if (rxs_q) begin
            state_d = BIT_IDLE;
          end
        end
        default: state_d = BIT_IDLE;
      endcase
    end
  end

  assign data      = shreg_q;
  assign byte_stb  = byte_stb_q;
  assign frame_err = frame_err_q;

endmodule

// File: rtl/icela_frame_rx.sv
// Logic-analyzer stream receiver: UART bytes -> sync-framed 32-bit capture words.
module icela_frame_rx
  import icela_frame_rx_pkg::*;
#(
  parameter int unsigned OS_WIDTH = OS_WIDTH_DEF,
  parameter int unsigned OS_INCR  = OS_INCR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [31:0] word,
  output logic        word_valid,
  output logic        frame_err,
  output logic [7:0]  err_cnt
);

  logic [7:0] rx_data;
  logic       rx_stb;
  logic       rx_ferr;

  logic [2:0]  fstate_q, fstate_d;
  logic [23:0] sreg_q, sreg_d;
  icela_word_t word_q, word_d;
  logic        word_valid_q, word_valid_d;
  logic        frame_err_q, frame_err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  uart_rx_os #(
    .OS_WIDTH (OS_WIDTH),
    .OS_INCR  (OS_INCR)
  ) u_uart (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data      (rx_data),
    .byte_stb  (rx_stb),
    .frame_err (rx_ferr)
  );

  // Frame FSM and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fstate_q     <= FRM_HUNT;
      sreg_q       <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      fstate_q     <= fstate_d;
      sreg_q       <= sreg_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      frame_err_q  <= frame_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  // Frame FSM next state: sync only recognised in HUNT, stop errors abort a partial frame
  always_comb begin
    fstate_d     = fstate_q;
    sreg_d       = sreg_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    frame_err_d  = rx_ferr;
    err_cnt_d    = rx_ferr ? sat_inc8(err_cnt_q) : err_cnt_q;
    if (rx_ferr) begin
      fstate_d = FRM_HUNT;
    end else if (rx_stb) begin
      case (fstate_q)
        FRM_HUNT: begin
          if (rx_data == SYNC_BYTE) begin
            fstate_d = FRM_P0;
          end
        end
        FRM_P0: begin
          sreg_d   = {sreg_q[15:0], rx_data};
          fstate_d = FRM_P1;
        end
        FRM_P1: begin
          sreg_d   = {sreg_q[15:0], rx_data};
          fstate_d = FRM_P2;
        end
        FRM_P2: begin
          sreg_d   = {sreg_q[15:0], rx_data};
          fstate_d = FRM_P3;
        end
        FRM_P3: begin
          word_d       = icela_word_t'({sreg_q, rx_data});
          word_valid_d = 1'b1;
          fstate_d     = FRM_HUNT;
        end
        default: fstate_d = FRM_HUNT;
      endcase
    end
  end

  assign word       = word_q;
  assign word_valid = word_valid_q;
  assign frame_err  = frame_err_q;
  assign err_cnt    = err_cnt_q;

endmodule
